// File: rtl/led_breath_sched_pkg.sv
// Shared types and constants for the RGB breathing LED sequencer.
package led_sched_pkg;
  localparam int DUTY_W     = 10;
  localparam int NUM_PHASES = 7;

  typedef enum logic [2:0] {IDLE, RAMP_UP, HOLD_HI, RAMP_DN, HOLD_LO} state_t;

  // {R,G,B} enable per colour phase; entry 0 sits in the low bits.
  localparam logic [NUM_PHASES-1:0][2:0] PHASE_MASK =
    {3'b111, 3'b101, 3'b011, 3'b110, 3'b001, 3'b010, 3'b100};

  function automatic logic [2:0] phase_mask(input logic [2:0] idx);
    return PHASE_MASK[idx];
  endfunction
endpackage

// File: rtl/led_breath_sched_if.sv
// Control inputs and PWM duty outputs of the breathing LED sequencer.
interface led_breath_sched_if;
  import led_sched_pkg::*;
  logic              en;
  logic              pause;
  logic [DUTY_W-1:0] duty_r;
  logic [DUTY_W-1:0] duty_g;
  logic [DUTY_W-1:0] duty_b;
  logic              duty_valid;
  logic [2:0]        phase_idx;
  logic              busy;

  modport master (output en, pause,
                  input  duty_r, duty_g, duty_b, duty_valid, phase_idx, busy);
  modport slave  (input  en, pause,
                  output duty_r, duty_g, duty_b, duty_valid, phase_idx, busy);
endinterface

// File: rtl/led_breath_sched_step_tick_gen.sv
// Brightness step strobe: one-cycle tick every TICK_DIV clocks while running.
module step_tick_gen #(
  parameter int CLK_FRE = 50,
  parameter int STEP_HZ = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic hold,
  output logic tick
);
  localparam int TICK_DIV = CLK_FRE * 1_000_000 / STEP_HZ;
  localparam int CW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // hold keeps the partial interval so a resume finishes it rather than restarting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt <= '0;
    else if (!run)   cnt <= '0;
    else if (!hold)  cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end

  assign tick = run && !hold && (cnt == LAST);
endmodule

// File: rtl/led_breath_sched.sv
// Breathing LED sequencer: ramps a shared level up/down per colour phase and drives three duties.
module led_breath_sched
  import led_sched_pkg::*;
#(
  parameter int CLK_FRE    = 50,
  parameter int STEP_HZ    = 100,
  parameter int DUTY_MAX   = 100,
  parameter int HOLD_STEPS = 50
) (
  input  logic              clk,
  input  logic              rst_n,
  led_breath_sched_if.slave bus
);
  localparam logic [DUTY_W-1:0] DMAX      = DUTY_W'(DUTY_MAX);
  localparam logic [9:0]        HOLD_LAST = 10'(HOLD_STEPS - 1);
  localparam logic [2:0]        PH_LAST   = 3'(NUM_PHASES - 1);

  state_t                  state_q, state_d;
  logic [DUTY_W-1:0]       level_q, level_d;
  logic [9:0]              hold_q, hold_d;
  logic [2:0]              phase_q, phase_d;
  logic [2:0]              mask;
  logic [2:0][DUTY_W-1:0]  duty_q, duty_d;
  logic                    dvld_q;
  logic                    tick;

  step_tick_gen #(.CLK_FRE(CLK_FRE), .STEP_HZ(STEP_HZ)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (bus.en && (state_q != IDLE)),
    .hold (bus.pause),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    hold_d  = hold_q;
    phase_d = phase_q;
    if (!bus.en) begin
      state_d = IDLE;
      level_d = '0;
      hold_d  = '0;
      phase_d = '0;
    end else if (!bus.pause) begin
      unique case (state_q)
        IDLE: begin
          state_d = RAMP_UP;
          level_d = '0;
          hold_d  = '0;
          phase_d = '0;
        end
        RAMP_UP: if (tick) begin
          level_d = (level_q < DMAX) ? level_q + 1'b1 : DMAX;
          if (level_d == DMAX) begin
            state_d = HOLD_HI;
            hold_d  = '0;
          end
        end
        HOLD_HI: if (tick) begin
          if (hold_q == HOLD_LAST) begin
            state_d = RAMP_DN;
            hold_d  = '0;
          end else hold_d = hold_q + 1'b1;
        end
        RAMP_DN: if (tick) begin
          level_d = (level_q != '0) ? level_q - 1'b1 : '0;
          if (level_d == '0) begin
            state_d = HOLD_LO;
            hold_d  = '0;
          end
        end
        HOLD_LO: if (tick) begin
          if (hold_q == HOLD_LAST) begin
            state_d = RAMP_UP;
            hold_d  = '0;
            phase_d = (phase_q == PH_LAST) ? 3'd0 : phase_q + 1'b1;
          end else hold_d = hold_q + 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // duties are registered from next-state values so they land with the level update
  always_comb begin
    mask = phase_mask(phase_d);
    for (int c = 0; c < 3; c++) duty_d[c] = mask[c] ? level_d : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      level_q <= '0;
      hold_q  <= '0;
      phase_q <= '0;
      duty_q  <= '0;
      dvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      hold_q  <= hold_d;
      phase_q <= phase_d;
      duty_q  <= duty_d;
      dvld_q  <= (duty_d != duty_q);
    end
  end

  assign bus.duty_r     = duty_q[2];
  assign bus.duty_g     = duty_q[1];
  assign bus.duty_b     = duty_q[0];
  assign bus.duty_valid = dvld_q;
  assign bus.phase_idx  = phase_q;
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_led_breath_sched.sv
// Scoreboard bench for led_breath_sched with TICK_DIV=10, DUTY_MAX=4, HOLD_STEPS=2.
module tb_led_breath_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   sb_on = 1'b0;

  typedef struct {
    int         at;
    logic [2:0] ph;
    logic [9:0] r, g, b;
  } exp_t;
  exp_t sbq[$];

  led_breath_sched_if bus();

  led_breath_sched #(.CLK_FRE(1), .STEP_HZ(100_000), .DUTY_MAX(4), .HOLD_STEPS(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [2:0] ref_mask(input int p);
    case (p)
      0: return 3'b100; 1: return 3'b010; 2: return 3'b001; 3: return 3'b110;
      4: return 3'b011; 5: return 3'b101; 6: return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  task automatic wait_valid(input int max, output int at, output bit ok);
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (bus.duty_valid) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
    chk("valid_timeout", 32'(ok), 32'd1);
  endtask

  always @(negedge clk) begin
    if (sb_on && bus.duty_valid) begin
      if (sbq.size() == 0) chk("spurious_valid", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_cycle", 32'(cyc), 32'(e.at));
        chk("sb_phase", 32'(bus.phase_idx), 32'(e.ph));
        chk("sb_rgb", {2'b0, bus.duty_r, bus.duty_g, bus.duty_b}, {2'b0, e.r, e.g, e.b});
      end
    end
  end

  initial begin
    int  c0, at, npulse;
    bit  ok;
    bus.en = 1'b0;
    bus.pause = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_rgb", {2'b0, bus.duty_r, bus.duty_g, bus.duty_b}, 32'd0);
    chk("rst_valid", 32'(bus.duty_valid), 32'd0);
    chk("rst_phase", 32'(bus.phase_idx), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 32'd0);

    // eight breaths: ramp 1..4 at ticks 1-4, down 3..0 at ticks 7-10, phase every 12 ticks
    c0 = cyc;
    for (int p = 0; p < 8; p++)
      for (int t = 1; t <= 8; t++) begin
        exp_t e;
        int   tk, lv;
        logic [2:0] m;
        tk   = 12 * p + ((t <= 4) ? t : t + 2);
        lv   = (t <= 4) ? t : 8 - t;
        m    = ref_mask(p % 7);
        e.at = c0 + 1 + 10 * tk;
        e.ph = 3'(p % 7);
        e.r  = m[2] ? 10'(lv) : 10'd0;
        e.g  = m[1] ? 10'(lv) : 10'd0;
        e.b  = m[0] ? 10'(lv) : 10'd0;
        sbq.push_back(e);
      end
    sb_on = 1'b1;
    bus.en = 1'b1;
    @(negedge clk);
    chk("busy_after_en", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 1100 && sbq.size() != 0; i++) @(negedge clk);
    chk("sb_drain", 32'(sbq.size()), 32'd0);
    repeat (5) @(negedge clk);
    sb_on = 1'b0;

    // restart, pause mid-ramp at level 2 for 37 clocks
    bus.en = 1'b0;
    repeat (2) @(negedge clk);
    chk("en_low_idle", 32'(bus.busy), 32'd0);
    c0 = cyc;
    bus.en = 1'b1;
    wait_valid(40, at, ok);
    chk("lvl1_at", 32'(at - c0), 32'd11);
    wait_valid(40, at, ok);
    chk("lvl2_at", 32'(at - c0), 32'd21);
    chk("lvl2_r", 32'(bus.duty_r), 32'd2);
    repeat (3) @(negedge clk);
    bus.pause = 1'b1;
    npulse = 0;
    for (int i = 0; i < 37; i++) begin
      @(negedge clk);
      if (bus.duty_valid) npulse++;
    end
    chk("pause_pulses", 32'(npulse), 32'd0);
    chk("pause_r", 32'(bus.duty_r), 32'd2);
    bus.pause = 1'b0;
    wait_valid(40, at, ok);
    chk("resume_at", 32'(at - c0), 32'd68);
    chk("resume_r", 32'(bus.duty_r), 32'd3);

    // en drop at level 3 while paused
    bus.pause = 1'b1;
    bus.en = 1'b0;
    @(negedge clk);
    chk("off_rgb", {2'b0, bus.duty_r, bus.duty_g, bus.duty_b}, 32'd0);
    chk("off_phase", 32'(bus.phase_idx), 32'd0);
    chk("off_busy", 32'(bus.busy), 32'd0);
    chk("off_valid", 32'(bus.duty_valid), 32'd1);
    @(negedge clk);
    chk("off_valid_once", 32'(bus.duty_valid), 32'd0);

    // async reset during HOLD_HI
    bus.pause = 1'b0;
    c0 = cyc;
    bus.en = 1'b1;
    for (int k = 0; k < 4; k++) wait_valid(40, at, ok);
    chk("peak_at", 32'(at - c0), 32'd41);
    repeat (4) @(negedge clk);
    chk("hold_r", 32'(bus.duty_r), 32'd4);
    chk("hold_busy", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rgb", {2'b0, bus.duty_r, bus.duty_g, bus.duty_b}, 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_phase", 32'(bus.phase_idx), 32'd0);
    bus.en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", 32'(bus.busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
